// File: rtl/fetch_predecode_fifo.sv
// rtl/fetch_predecode_fifo.sv - fetch packet queue with enqueue-time predecode
// Head is read combinationally from storage; privileged packets optionally stall the output until commit.
module fetch_predecode_fifo #(
  parameter int FETCH_W     = 2,
  parameter int DEPTH       = 8,
  parameter int PRIV_SERIAL = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          flush,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [31:0]                                   in_pc,
  input  logic [32*FETCH_W-1:0]                         in_inst,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [31:0]                                   out_pc,
  output logic [32*FETCH_W-1:0]                         out_inst,
  output logic [FETCH_W-1:0]                            out_lane_valid,
  output logic [2*FETCH_W-1:0]                          out_btype,
  output logic [FETCH_W-1:0]                            out_priv,
  output logic [FETCH_W-1:0]                            out_ibar,
  output logic [FETCH_W-1:0]                            out_csr,
  output logic [FETCH_W-1:0]                            out_tlb,
  output logic                                          out_br_hit,
  output logic [((FETCH_W > 1) ? $clog2(FETCH_W) : 1)-1:0] out_br_pos,
  output logic [1:0]                                    out_br_type,
  input  logic                                          priv_commit,
  output logic [$clog2(DEPTH):0]                        count
);

  localparam int LW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {RUN = 1'b0, WAIT_PRIV = 1'b1} state_t;

  typedef struct packed {
    logic [31:0]            pc;
    logic [32*FETCH_W-1:0]  inst;
    logic [FETCH_W-1:0]     lv;
    logic [2*FETCH_W-1:0]   bt;
    logic [FETCH_W-1:0]     ibar;
    logic [FETCH_W-1:0]     csr;
    logic [FETCH_W-1:0]     tlb;
    logic                   br_hit;
    logic [LW-1:0]          br_pos;
    logic [1:0]             br_type;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        pd_d;
  entry_t        head;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic [PW:0]   count_d;
  state_t        state_q;
  logic          push;
  logic          pop;
  logic [31:0]   lane_base;
  logic [31:0]   lane_k;
  logic [1:0]    lane_bt;

  assign lane_base = (in_pc >> 2) & 32'(FETCH_W - 1);

  // Walk lanes high to low so the lowest valid branch lane ends up in br_pos/br_type.
  always_comb begin
    pd_d      = '0;
    pd_d.pc   = in_pc;
    pd_d.inst = in_inst;
    lane_k    = '0;
    lane_bt   = 2'b00;
    for (int i = FETCH_W - 1; i >= 0; i--) begin
      lane_k = in_inst[32*i +: 32];
      if (lane_k[31:27] == 5'b01010)
        lane_bt = 2'b01;
      else if (lane_k[31:27] == 5'b01011 || lane_k[31:28] == 4'b0110)
        lane_bt = 2'b10;
      else if (lane_k[31:26] == 6'b010011)
        lane_bt = 2'b11;
      else
        lane_bt = 2'b00;
      if (32'(i) >= lane_base) begin
        pd_d.lv[i]        = 1'b1;
        pd_d.bt[2*i +: 2] = lane_bt;
        pd_d.ibar[i]      = lane_k[31:15] == 17'b00111000011100101;
        pd_d.csr[i]       = lane_k[31:24] == 8'h04 && lane_k[9:5] != 5'd0;
        pd_d.tlb[i]       = lane_k == 32'h06483000 || lane_k == 32'h06483400 ||
                            lane_k[31:15] == 17'b00000110010010011;
        if (lane_bt != 2'b00) begin
          pd_d.br_hit  = 1'b1;
          pd_d.br_pos  = LW'(i);
          pd_d.br_type = lane_bt;
        end
      end
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign in_ready  = count_q != (PW+1)'(DEPTH);
  assign out_valid = (count_q != '0) && (state_q == RUN);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign out_pc         = head.pc;
  assign out_inst       = head.inst;
  assign out_lane_valid = head.lv;
  assign out_btype      = head.bt;
  assign out_ibar       = head.ibar;
  assign out_csr        = head.csr;
  assign out_tlb        = head.tlb;
  assign out_priv       = head.ibar | head.csr | head.tlb;
  assign out_br_hit     = head.br_hit;
  assign out_br_pos     = head.br_pos;
  assign out_br_type    = head.br_type;
  assign count          = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (PW+1)'(1);
    else if (pop && !push)
      count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= pd_d;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= RUN;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      case (state_q)
        RUN:       if (PRIV_SERIAL != 0 && pop && (|out_priv)) state_q <= WAIT_PRIV;
        WAIT_PRIV: if (priv_commit) state_q <= RUN;
        default:   state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_predecode_fifo.sv
// tb/tb_fetch_predecode_fifo.sv - self-checking bench for fetch_predecode_fifo
module tb_fetch_predecode_fifo;

  localparam int FW = 2;
  localparam int D  = 8;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [63:0]   in_inst;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [63:0]   out_inst;
  logic [1:0]    out_lane_valid;
  logic [3:0]    out_btype;
  logic [1:0]    out_priv;
  logic [1:0]    out_ibar;
  logic [1:0]    out_csr;
  logic [1:0]    out_tlb;
  logic          out_br_hit;
  logic [0:0]    out_br_pos;
  logic [1:0]    out_br_type;
  logic          priv_commit;
  logic [3:0]    count;

  fetch_predecode_fifo #(.FETCH_W(FW), .DEPTH(D), .PRIV_SERIAL(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_lane_valid(out_lane_valid),
    .out_btype(out_btype), .out_priv(out_priv), .out_ibar(out_ibar), .out_csr(out_csr),
    .out_tlb(out_tlb), .out_br_hit(out_br_hit), .out_br_pos(out_br_pos),
    .out_br_type(out_br_type), .priv_commit(priv_commit), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] inst;
  } pkt_t;

  typedef struct packed {
    logic [1:0] lv;
    logic [3:0] bt;
    logic [1:0] ibar;
    logic [1:0] csr;
    logic [1:0] tlb;
    logic       hit;
    logic       pos;
    logic [1:0] btyp;
  } dec_t;

  pkt_t q[$];
  bit   wait_m;
  int   n_checks;
  int   n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int br_class(input logic [31:0] k);
    if ((k & 32'hF800_0000) == 32'h5000_0000) return 1;
    if ((k & 32'hF800_0000) == 32'h5800_0000) return 2;
    if ((k & 32'hF000_0000) == 32'h6000_0000) return 2;
    if ((k & 32'hFC00_0000) == 32'h4C00_0000) return 3;
    return 0;
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] pc, input logic [63:0] inst);
    dec_t        d;
    int          first;
    int          bc;
    logic [31:0] k;
    d     = '0;
    first = int'((pc / 4) % FW);
    for (int lane = 0; lane < FW; lane++) begin
      if (lane >= first) begin
        k  = inst[32*lane +: 32];
        bc = br_class(k);
        d.lv[lane]        = 1'b1;
        d.bt[2*lane +: 2] = 2'(bc);
        d.ibar[lane]      = (k & 32'hFFFF_8000) == 32'h3872_8000;
        d.csr[lane]       = (k >> 24) == 32'h04 && ((k >> 5) % 32) != 0;
        d.tlb[lane]       = k == 32'h0648_3000 || k == 32'h0648_3400 ||
                            (k & 32'hFFFF_8000) == 32'h0649_8000;
        if (bc != 0 && !d.hit) begin
          d.hit  = 1'b1;
          d.pos  = 1'(lane);
          d.btyp = 2'(bc);
        end
      end
    end
    return d;
  endfunction

  // Compare against the model, then advance the model by the events of this cycle.
  task automatic step_model();
    bit   er;
    bit   ev;
    dec_t d;
    er = q.size() != D;
    ev = q.size() != 0 && !wait_m;
    d  = '0;
    check("in_ready", 64'(in_ready), 64'(er));
    check("out_valid", 64'(out_valid), 64'(ev));
    check("count", 64'(count), 64'(q.size()));
    if (ev) begin
      d = ref_decode(q[0].pc, q[0].inst);
      check("out_pc", 64'(out_pc), 64'(q[0].pc));
      check("out_inst", out_inst, q[0].inst);
      check("out_lane_valid", 64'(out_lane_valid), 64'(d.lv));
      check("out_btype", 64'(out_btype), 64'(d.bt));
      check("out_ibar", 64'(out_ibar), 64'(d.ibar));
      check("out_csr", 64'(out_csr), 64'(d.csr));
      check("out_tlb", 64'(out_tlb), 64'(d.tlb));
      check("out_priv", 64'(out_priv), 64'(d.ibar | d.csr | d.tlb));
      check("out_br_hit", 64'(out_br_hit), 64'(d.hit));
      check("out_br_pos", 64'(out_br_pos), 64'(d.pos));
      check("out_br_type", 64'(out_br_type), 64'(d.btyp));
    end
    if (rst || flush) begin
      q.delete();
      wait_m = 1'b0;
    end else begin
      if (ev && out_ready) begin
        if ((d.ibar | d.csr | d.tlb) != 2'b00) wait_m = 1'b1;
        void'(q.pop_front());
      end else if (wait_m && priv_commit) begin
        wait_m = 1'b0;
      end
      if (in_valid && er) q.push_back('{in_pc, in_inst});
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [31:0] pc, input logic [63:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic commit();
    priv_commit = 1'b1;
    cycle();
    priv_commit = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 9)
      0: return 32'h5000_0000 | (r & 32'h07FF_FFFF);
      1: return 32'h5800_0000 | (r & 32'h07FF_FFFF);
      2: return 32'h6000_0000 | (r & 32'h0FFF_FFFF);
      3: return 32'h4C00_0000 | (r & 32'h03FF_FFFF);
      4: return 32'h3872_8000 | (r & 32'h0000_7FFF);
      5: return 32'h0400_0000 | (r & 32'h00FF_FC1F) | ((r % 2 == 0) ? 32'h0 : 32'h0000_0060);
      6: return (r % 3 == 0) ? 32'h0648_3000 : (r % 3 == 1) ? 32'h0648_3400 :
                32'h0649_8000 | (r & 32'h0000_7FFF);
      7: return 32'h0340_0000;
      default: return r;
    endcase
  endfunction

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    wait_m      = 1'b0;
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_pc       = '0;
    in_inst     = '0;
    out_ready   = 1'b0;
    priv_commit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_count", 64'(count), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);

    // Misaligned PC masks lane 0, hiding its branch.
    push_pkt(32'h1c00_0004, {32'h0280_0000, 32'h5000_0400});
    check("t1_lane_valid", 64'(out_lane_valid), 64'b10);
    check("t1_btype", 64'(out_btype), 64'b0000);
    check("t1_br_hit", 64'(out_br_hit), 64'd0);
    pop_one();

    push_pkt(32'h1c00_0000, {32'h4c00_0020, 32'h5800_0000});
    check("t2_btype", 64'(out_btype), 64'b1110);
    check("t2_br_hit", 64'(out_br_hit), 64'd1);
    check("t2_br_pos", 64'(out_br_pos), 64'd0);
    check("t2_br_type", 64'(out_br_type), 64'b10);
    pop_one();

    for (int i = 0; i < D; i++)
      push_pkt(32'h1c00_0100 + 32'(8 * i), {32'h0280_0000 + 32'(i), 32'h5000_0000 + 32'(i)});
    check("t3_full_count", 64'(count), 64'd8);
    check("t3_full_in_ready", 64'(in_ready), 64'd0);
    push_pkt(32'h1c00_0f00, {32'h0340_0000, 32'h0340_0000});
    check("t3_no_overfill", 64'(count), 64'd8);
    pop_one();
    check("t3_count7", 64'(count), 64'd7);
    in_valid  = 1'b1;
    in_pc     = 32'h1c00_0180;
    in_inst   = {32'h0340_0000, 32'h6000_0000};
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("t3_push_pop_count", 64'(count), 64'd7);
    for (int i = 0; i < 20 && count != 0; i++) cycle();
    out_ready = 1'b0;
    check("t3_drained", 64'(count), 64'd0);

    push_pkt(32'h1c00_0200, {32'h0340_0000, 32'h0400_0020});
    push_pkt(32'h1c00_0208, {32'h0340_0000, 32'h3872_8000});
    check("t4_out_csr", 64'(out_csr), 64'b01);
    pop_one();
    check("t4_stalled", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_still_stalled", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;
    commit();
    check("t4_released", 64'(out_valid), 64'd1);
    check("t4_out_ibar", 64'(out_ibar), 64'b01);
    pop_one();
    commit();

    push_pkt(32'h1c00_0300, {32'h0649_8000, 32'h0648_3400});
    check("t5_out_tlb", 64'(out_tlb), 64'b11);
    check("t5_out_priv", 64'(out_priv), 64'b11);
    pop_one();
    commit();
    push_pkt(32'h1c00_0308, {32'h0340_0000, 32'h0400_0000});
    check("t5_csr_rj0", 64'(out_csr), 64'b00);
    pop_one();

    push_pkt(32'h1c00_0400, {32'h0340_0000, 32'h3872_8000});
    for (int i = 0; i < 5; i++) push_pkt(32'h1c00_0408 + 32'(8 * i), {32'h0340_0000, 32'h0340_0000});
    pop_one();
    check("t6_count5", 64'(count), 64'd5);
    check("t6_wait", 64'(out_valid), 64'd0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h1c00_0500;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t6_flush_count", 64'(count), 64'd0);
    check("t6_flush_out_valid", 64'(out_valid), 64'd0);
    push_pkt(32'h1c00_0600, {32'h0340_0000, 32'h0340_0000});
    check("t6_run_again", 64'(out_valid), 64'd1);
    check("t6_head_pc", 64'(out_pc), 64'h1c00_0600);
    pop_one();

    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom % 400) == 0;
      flush       = ($urandom % 60) == 0;
      in_valid    = ($urandom % 10) < 7;
      out_ready   = ($urandom % 10) < 6;
      priv_commit = ($urandom % 6) == 0;
      in_pc       = 32'h1c00_0000 + ($urandom % 4096) * 4;
      in_inst     = {rand_inst(), rand_inst()};
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
